// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery square-and-multiply exponentiation controller.
package mont_pkg;

    localparam int NBITS_DEF = 2048;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SQR_ISS = 3'd1,
        ST_SQR_WT  = 3'd2,
        ST_MUL_ISS = 3'd3,
        ST_MUL_WT  = 3'd4,
        ST_OUT_ISS = 3'd5,
        ST_OUT_WT  = 3'd6,
        ST_DONE    = 3'd7
    } mont_exp_state_t;

    function automatic int len_width(input int ebits);
        return $clog2(ebits + 1);
    endfunction

endpackage

// File: rtl/mont_wdog.sv
// Loadable up-counter that flags when a multiplier wait has lasted LIMIT cycles.
module mont_wdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_r;

    // Wait-cycle counter; saturates at LIMIT so a stuck wait can never wrap back to quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (run && (cnt_r != CW'(LIMIT))) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The counter reads k-1 in the k-th wait cycle, so LIMIT-1 means this is the LIMIT-th cycle.
    assign expired = run && (cnt_r >= CW'(LIMIT - 1));

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier; a final
// multiply by 1 converts the Montgomery-domain accumulator back to the plain residue.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int NBITS       = NBITS_DEF,
    parameter int EBITS       = 2048,
    parameter int LENW        = len_width(EBITS),
    parameter int MUL_LAT_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_p,
    input  logic [NBITS-1:0] base_m,
    input  logic [NBITS-1:0] one_m,
    input  logic [EBITS-1:0] exp,
    input  logic [LENW-1:0]  e_len,
    output logic             mul_en_p,
    output logic [NBITS-1:0] mul_a,
    output logic [NBITS-1:0] mul_b,
    input  logic [NBITS-1:0] mul_y,
    input  logic             mul_done_p,
    output logic [NBITS-1:0] result,
    output logic             done_p,
    output logic             busy,
    output logic             err
);

    mont_exp_state_t state_r, state_nx_s;

    logic [NBITS-1:0] acc_r, acc_nx_s, base_r, result_r, mul_a_r, mul_b_r, mul_a_nx_s, mul_b_nx_s;
    logic [EBITS-1:0] exp_r, bit_mask_s;
    logic [LENW-1:0]  idx_r, idx_nx_s, elen_c_s;
    logic             cur_bit_s, capture_s, err_set_s, err_clr_s, res_ld_s;
    logic             wd_clr_s, wd_run_s, wd_exp_s, issue_s;
    logic             mul_en_r, done_r, busy_r, err_r;

    assign elen_c_s   = (e_len > LENW'(EBITS)) ? LENW'(EBITS) : e_len;
    assign bit_mask_s = {{(EBITS-1){1'b0}}, 1'b1} << idx_r;
    assign cur_bit_s  = |(exp_r & bit_mask_s);

    mont_wdog #(.LIMIT(MUL_LAT_MAX)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr_s),
        .run     (wd_run_s),
        .expired (wd_exp_s)
    );

    // Next-state and datapath control; a done pulse takes priority over a same-cycle expiry.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        idx_nx_s   = idx_r;
        capture_s  = 1'b0;
        err_set_s  = 1'b0;
        err_clr_s  = 1'b0;
        res_ld_s   = 1'b0;
        wd_clr_s   = 1'b0;
        wd_run_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_p) begin
                    capture_s  = 1'b1;
                    err_clr_s  = 1'b1;
                    acc_nx_s   = one_m;
                    idx_nx_s   = elen_c_s;
                    state_nx_s = (elen_c_s != {LENW{1'b0}}) ? ST_SQR_ISS : ST_OUT_ISS;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SQR_ISS: begin
                wd_clr_s   = 1'b1;
                idx_nx_s   = idx_r - LENW'(1);
                state_nx_s = ST_SQR_WT;
            end
            ST_SQR_WT: begin
                wd_run_s = 1'b1;
                if (mul_done_p) begin
                    acc_nx_s = mul_y;
                    if (cur_bit_s) begin
                        state_nx_s = ST_MUL_ISS;
                    end else if (idx_r == {LENW{1'b0}}) begin
                        state_nx_s = ST_OUT_ISS;
                    end else begin
                        state_nx_s = ST_SQR_ISS;
                    end
                end else if (wd_exp_s) begin
                    err_set_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SQR_WT;
                end
            end
            ST_MUL_ISS: begin
                wd_clr_s   = 1'b1;
                state_nx_s = ST_MUL_WT;
            end
            ST_MUL_WT: begin
                wd_run_s = 1'b1;
                if (mul_done_p) begin
                    acc_nx_s   = mul_y;
                    state_nx_s = (idx_r == {LENW{1'b0}}) ? ST_OUT_ISS : ST_SQR_ISS;
                end else if (wd_exp_s) begin
                    err_set_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_MUL_WT;
                end
            end
            ST_OUT_ISS: begin
                wd_clr_s   = 1'b1;
                state_nx_s = ST_OUT_WT;
            end
            ST_OUT_WT: begin
                wd_run_s = 1'b1;
                if (mul_done_p) begin
                    res_ld_s   = 1'b1;
                    state_nx_s = ST_DONE;
                end else if (wd_exp_s) begin
                    err_set_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_OUT_WT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Operands are loaded on entry to an issue state so they are already stable when the enable fires.
    always_comb begin
        issue_s    = 1'b0;
        mul_a_nx_s = mul_a_r;
        mul_b_nx_s = mul_b_r;
        case (state_nx_s)
            ST_SQR_ISS: begin
                issue_s    = 1'b1;
                mul_a_nx_s = acc_nx_s;
                mul_b_nx_s = acc_nx_s;
            end
            ST_MUL_ISS: begin
                issue_s    = 1'b1;
                mul_a_nx_s = acc_nx_s;
                mul_b_nx_s = base_r;
            end
            ST_OUT_ISS: begin
                issue_s    = 1'b1;
                mul_a_nx_s = acc_nx_s;
                mul_b_nx_s = {{(NBITS-1){1'b0}}, 1'b1};
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            acc_r    <= {NBITS{1'b0}};
            base_r   <= {NBITS{1'b0}};
            exp_r    <= {EBITS{1'b0}};
            idx_r    <= {LENW{1'b0}};
            result_r <= {NBITS{1'b0}};
            mul_a_r  <= {NBITS{1'b0}};
            mul_b_r  <= {NBITS{1'b0}};
            mul_en_r <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            acc_r    <= acc_nx_s;
            idx_r    <= idx_nx_s;
            base_r   <= capture_s ? base_m : base_r;
            exp_r    <= capture_s ? exp : exp_r;
            result_r <= res_ld_s ? mul_y : result_r;
            mul_a_r  <= mul_a_nx_s;
            mul_b_r  <= mul_b_nx_s;
            mul_en_r <= issue_s;
            done_r   <= (state_nx_s == ST_DONE);
            busy_r   <= (state_nx_s != ST_IDLE);
            if (err_clr_s) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Reset kills a pending enable in the very cycle it is asserted.
    assign mul_en_p = mul_en_r & ~rst;
    assign mul_a    = mul_a_r;
    assign mul_b    = mul_b_r;
    assign result   = result_r;
    assign done_p   = done_r;
    assign busy     = busy_r;
    assign err      = err_r;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier (m=65521, R=2^16) plus a
// plain-arithmetic modular-exponentiation reference.
module tb_mont_exp_ctrl;

    localparam longint M = 65521;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_p = 1'b0;
    logic [15:0] base_m = 16'd0, one_m = 16'd0, exp = 16'd0;
    logic [4:0]  e_len = 5'd0;
    logic        mul_en_p, done_p, busy, err;
    logic [15:0] mul_a, mul_b, result;
    logic [15:0] mul_y = 16'd0;
    logic        mul_done_p = 1'b0;

    int n_checks = 0, n_fail = 0;
    int lat = 4, suppress_at = -1, pulse_cnt = 0, mcnt = 0, pend_idx = 0;
    logic [15:0] pend_y = 16'd0, last_a = 16'd0, last_b = 16'd0;

    mont_exp_ctrl #(.NBITS(16), .EBITS(16), .MUL_LAT_MAX(8)) dut (
        .clk(clk), .rst(rst), .start_p(start_p), .base_m(base_m), .one_m(one_m),
        .exp(exp), .e_len(e_len), .mul_en_p(mul_en_p), .mul_a(mul_a), .mul_b(mul_b),
        .mul_y(mul_y), .mul_done_p(mul_done_p), .result(result), .done_p(done_p),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mont(input logic [15:0] a, input logic [15:0] b);
        longint t;
        t = longint'(a) * longint'(b);
        for (int i = 0; i < 16; i++) begin
            if (t % 2 == 1) t = t + M;
            t = t / 2;
        end
        if (t >= M) t = t - M;
        return t[15:0];
    endfunction

    function automatic longint powmod(input longint b, input longint e);
        longint r = 1;
        b = b % M;
        while (e > 0) begin
            if (e % 2 == 1) r = (r * b) % M;
            b = (b * b) % M;
            e = e / 2;
        end
        return r;
    endfunction

    function automatic int clamp_len(input int el);
        return (el > 16) ? 16 : el;
    endfunction

    function automatic longint masked_exp(input logic [15:0] e, input int el);
        return longint'(e) % (longint'(1) << clamp_len(el));
    endfunction

    function automatic int exp_pulses(input logic [15:0] e, input int el);
        return clamp_len(el) + $countones(masked_exp(e, el)) + 1;
    endfunction

    // Behavioural multiplier: done 'lat' cycles after the enable; one chosen issue can be swallowed.
    always @(posedge clk) begin
        mul_done_p <= 1'b0;
        if (mul_en_p) begin
            pulse_cnt <= pulse_cnt + 1;
            last_a    <= mul_a;
            last_b    <= mul_b;
            if (lat <= 1) begin
                mul_y      <= mont(mul_a, mul_b);
                mul_done_p <= (pulse_cnt + 1 != suppress_at);
                mcnt       <= 0;
            end else begin
                pend_y   <= mont(mul_a, mul_b);
                pend_idx <= pulse_cnt + 1;
                mcnt     <= lat - 1;
            end
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mul_y      <= pend_y;
                mul_done_p <= (pend_idx != suppress_at);
            end
        end
    end

    task automatic do_run(input logic [15:0] bm, input logic [15:0] e, input int el, input int l,
                          input int poke, output bit saw_done, output int pulses,
                          output int gap, output logic err0, output bit tmo);
        int p0;
        repeat (2) @(negedge clk);
        lat = l; base_m = bm; one_m = 16'd15; exp = e; e_len = 5'(el); start_p = 1'b1;
        p0 = pulse_cnt;
        saw_done = 1'b0; tmo = 1'b1; gap = 0; err0 = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start_p = (i == poke) ? 1'b1 : 1'b0;
            if (i == poke) begin
                base_m = ~base_m; exp = ~exp;
            end
            if (i == 0) err0 = err;
            if (done_p) begin saw_done = 1'b1; tmo = 1'b0; break; end
            if (!busy) begin tmo = 1'b0; break; end
            if (mul_en_p) gap = 0; else gap++;
        end
        start_p = 1'b0;
        pulses = pulse_cnt - p0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if ({busy, done_p, err, mul_en_p} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, done_p, err, mul_en_p}); end
        n_checks++; if ({result, mul_a, mul_b} !== 48'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", {result, mul_a, mul_b}); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        bit d, t; int p, g; logic e0;
        do_run(16'd45, 16'd5, 3, 4, -1, d, p, g, e0, t);
        n_checks++; if (t || !d) begin n_fail++; $display("FAIL basic_done got done=%0d timeout=%0d want done=1", d, t); end
        n_checks++; if (result !== 16'd243) begin n_fail++; $display("FAIL basic_result got %0d want 243", result); end
        n_checks++; if (p != 6) begin n_fail++; $display("FAIL basic_pulses got %0d want 6", p); end
        @(negedge clk);
        n_checks++; if ({done_p, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_after got done_p,busy=%b want 00", {done_p, busy}); end
    endtask

    task automatic test_zero_exp();
        bit d, t; int p, g; logic e0;
        do_run(16'd45, 16'd0, 0, 4, -1, d, p, g, e0, t);
        n_checks++; if (t || !d) begin n_fail++; $display("FAIL zero_done got done=%0d timeout=%0d want done=1", d, t); end
        n_checks++; if (p != 1) begin n_fail++; $display("FAIL zero_pulses got %0d want 1", p); end
        n_checks++; if ({last_a, last_b} !== {16'd15, 16'd1}) begin n_fail++; $display("FAIL zero_operands got a=%0d b=%0d want a=15 b=1", last_a, last_b); end
        n_checks++; if (result !== 16'd1) begin n_fail++; $display("FAIL zero_result got %0d want 1", result); end
    endtask

    task automatic test_fermat();
        bit d, t; int p, g; logic e0;
        int lens[2] = '{16, 31};
        foreach (lens[k]) begin
            do_run(16'd105, 16'd65520, lens[k], 3, -1, d, p, g, e0, t);
            n_checks++; if (t || !d) begin n_fail++; $display("FAIL fermat_done e_len=%0d got done=%0d want 1", lens[k], d); end
            n_checks++; if (result !== 16'd1) begin n_fail++; $display("FAIL fermat_result e_len=%0d got %0d want 1", lens[k], result); end
            n_checks++; if (p != 29) begin n_fail++; $display("FAIL fermat_pulses e_len=%0d got %0d want 29", lens[k], p); end
        end
    endtask

    task automatic test_watchdog();
        bit d, t; int p, g; logic e0;
        do_run(16'd45, 16'd5, 3, 4, -1, d, p, g, e0, t);
        suppress_at = pulse_cnt + 2;
        do_run(16'd105, 16'd5, 3, 4, -1, d, p, g, e0, t);
        suppress_at = -1;
        n_checks++; if (t || d) begin n_fail++; $display("FAIL wd_no_done got done=%0d timeout=%0d want 0,0", d, t); end
        n_checks++; if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL wd_flags got err,busy=%b want 10", {err, busy}); end
        n_checks++; if (g != 8) begin n_fail++; $display("FAIL wd_wait_cycles got %0d want 8", g); end
        n_checks++; if (p != 2) begin n_fail++; $display("FAIL wd_pulses got %0d want 2", p); end
        n_checks++; if (result !== 16'd243) begin n_fail++; $display("FAIL wd_result_held got %0d want 243", result); end
        do_run(16'd45, 16'd5, 3, 4, -1, d, p, g, e0, t);
        n_checks++; if (e0 !== 1'b0) begin n_fail++; $display("FAIL wd_err_cleared got %b want 0", e0); end
        n_checks++; if (!d || result !== 16'd243 || err !== 1'b0) begin n_fail++; $display("FAIL wd_recover got done=%0d result=%0d err=%b want 1,243,0", d, result, err); end
    endtask

    task automatic test_busy_restart();
        bit d, t; int p, g; logic e0; logic [15:0] e16;
        longint b, want;
        b = longint'($urandom_range(2, 65520)); e16 = 16'($urandom) | 16'h8000;
        want = powmod(b, masked_exp(e16, 16));
        do_run(16'((b * 15) % M), e16, 16, 5, 6, d, p, g, e0, t);
        n_checks++; if (!d || longint'(result) != want) begin n_fail++; $display("FAIL restart_result got done=%0d %0d want 1,%0d", d, result, want); end
        n_checks++; if (p != exp_pulses(e16, 16)) begin n_fail++; $display("FAIL restart_pulses got %0d want %0d", p, exp_pulses(e16, 16)); end
    endtask

    task automatic test_latency_sweep();
        bit d, t; int p, g; logic e0;
        longint want;
        want = powmod(11, 16'hB3C5);
        for (int l = 1; l <= 10; l++) begin
            do_run(16'd165, 16'hB3C5, 16, l, -1, d, p, g, e0, t);
            if (l <= 8) begin
                n_checks++; if (!d || longint'(result) != want || p != exp_pulses(16'hB3C5, 16)) begin n_fail++; $display("FAIL lat_sweep lat=%0d got done=%0d res=%0d pulses=%0d want 1,%0d,%0d", l, d, result, p, want, exp_pulses(16'hB3C5, 16)); end
            end else begin
                n_checks++; if (d || err !== 1'b1 || p != 1) begin n_fail++; $display("FAIL lat_timeout lat=%0d got done=%0d err=%b pulses=%0d want 0,1,1", l, d, err, p); end
            end
        end
    endtask

    task automatic test_random();
        bit d, t; int p, g, el, l; logic e0; logic [15:0] e16;
        longint b, want;
        for (int k = 0; k < 14; k++) begin
            b = longint'($urandom_range(0, 65520)); e16 = 16'($urandom);
            el = $urandom_range(0, 16); l = $urandom_range(1, 8);
            want = powmod(b, masked_exp(e16, el));
            do_run(16'((b * 15) % M), e16, el, l, -1, d, p, g, e0, t);
            n_checks++; if (!d || longint'(result) != want || p != exp_pulses(e16, el)) begin n_fail++; $display("FAIL random base=%0d exp=%h len=%0d got done=%0d res=%0d pulses=%0d want %0d,%0d", b, e16, el, d, result, p, want, exp_pulses(e16, el)); end
        end
    endtask

    task automatic test_rst_abort();
        int seen;
        repeat (2) @(negedge clk);
        lat = 6; base_m = 16'd45; one_m = 16'd15; exp = 16'd5; e_len = 5'd3; start_p = 1'b1;
        @(negedge clk); start_p = 1'b0;
        rst = 1'b1; #1;
        n_checks++; if (mul_en_p !== 1'b0) begin n_fail++; $display("FAIL rst_gates_en got %b want 0", mul_en_p); end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        start_p = 1'b1;
        @(negedge clk); start_p = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_p || busy || mul_en_p) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_stray_done got %0d active cycles want 0", seen); end
        n_checks++; if ({result, mul_a, mul_b, err} !== 49'd0) begin n_fail++; $display("FAIL rst_outputs got %h want 0", {result, mul_a, mul_b, err}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_exp();
        test_fermat();
        test_watchdog();
        test_busy_restart();
        test_latency_sweep();
        test_random();
        test_rst_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
